// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: transmitter states, protocol constants and the header ECC.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package csi2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LP01,
    ST_LP00,
    ST_HS_ZERO,
    ST_SYNC,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_CRC,
    ST_TRAIL
  } state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'hB8;
  localparam logic [15:0] CRC_SEED    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h8408;  // x^16+x^12+x^5+1, bit-reversed
  localparam logic [5:0]  DT_LONG_MIN = 6'h10;     // data types at or above this are long packets

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  // Header ECC: each parity bit is the XOR of the header bits selected by its mask.
  // hdr[7:0] = {vc, dt}, hdr[23:8] = word count. Bits [7:6] of the result are zero.
  function automatic logic [7:0] ecc6(input logic [23:0] hdr);
    logic [5:0] p;
    p[0] = ^(hdr & 24'hF12CB7);
    p[1] = ^(hdr & 24'hF2555B);
    p[2] = ^(hdr & 24'h749A6D);
    p[3] = ^(hdr & 24'hB8E38E);
    p[4] = ^(hdr & 24'hDF03F0);
    p[5] = ^(hdr & 24'hEFFC00);
    return {2'b00, p};
  endfunction

endpackage

// File: rtl/csi2_packet_tx_if.sv
// Command and payload handshake bundle between a packet source and the CSI-2 transmitter.
// Latency: n/a (wires only).
// Backpressure: cmd_ready / data_ready are driven by the transmitter (slave side).
// Ports: cmd_valid/cmd_ready/cmd_vc/cmd_type/cmd_wc request a packet; data_i/data_valid/data_ready carry payload words.
interface csi2_packet_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_type;
  logic [15:0] cmd_wc;
  logic [15:0] data_i;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output cmd_valid, cmd_vc, cmd_type, cmd_wc, data_i, data_valid,
    input  cmd_ready, data_ready
  );

  modport slave (
    input  cmd_valid, cmd_vc, cmd_type, cmd_wc, data_i, data_valid,
    output cmd_ready, data_ready
  );
endinterface

// File: rtl/csi2_crc16_2byte.sv
// CSI-2 payload CRC16 (reflected 0x8408), two bytes per clock, byte0 first, LSB first; also used by the receiver check.
// Latency: crc reflects the bytes presented with en one clock later; init reloads the seed.
// Backpressure: none; the caller decides when en is asserted.
// Ports: clk, rst (sync, active-high), init, en, byte0, byte1 in; crc out.
module csi2_crc16_2byte
  import csi2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  output logic [15:0] crc
);

  function automatic logic [15:0] step8(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_SEED;
    end else if (en) begin
      crc <= step8(step8(crc, byte0), byte1);
    end
  end

endmodule

// File: rtl/csi2_packet_tx.sv
// Two-lane CSI-2 packet transmitter: LP11->LP01->LP00->HS-zero, sync, header+ECC, payload, CRC16, trail, back to LP11.
// Latency: sync byte appears T_LPX+T_PREPARE+T_ZERO+1 cycles after the accepting cycle; byte outputs decode the state.
// Backpressure: cmd_ready only in IDLE after T_EXIT LP11 cycles; HS never pauses, missing payload is sent as 0x00.
// Ports: sys_clk, reset (sync, active-high), host (slave modport: command + payload handshake),
//        lane0_byte/lane1_byte/hs_en to the serializers, lp_p/lp_n to the LP buffers, busy and error pulses.
module csi2_packet_tx
  import csi2_pkg::*;
#(
  parameter int T_LPX     = 2,
  parameter int T_PREPARE = 2,
  parameter int T_ZERO    = 6,
  parameter int T_TRAIL   = 4,
  parameter int T_EXIT    = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  csi2_packet_tx_if.slave   host,
  output logic [7:0]        lane0_byte,
  output logic [7:0]        lane1_byte,
  output logic              hs_en,
  output logic              lp_p,
  output logic              lp_n,
  output logic              busy,
  output logic              err_underrun,
  output logic              err_odd_wc
);

  // Timed states count cnt from N-1 down to 0, so they last exactly N cycles.
  localparam logic [15:0] LPX_LOAD   = 16'(T_LPX - 1);
  localparam logic [15:0] PREP_LOAD  = 16'(T_PREPARE - 1);
  localparam logic [15:0] ZERO_LOAD  = 16'(T_ZERO - 1);
  localparam logic [15:0] TRAIL_LOAD = 16'(T_TRAIL - 1);
  localparam logic [7:0]  EXIT_MAX   = 8'(T_EXIT);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  exit_cnt;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        last0_b7, last1_b7;
  logic [15:0] crc;
  logic        crc_init, crc_en;
  logic        accept, cmd_long, odd_reject, pkt_long, trail_done;

  assign host.cmd_ready = (state == ST_IDLE) && (exit_cnt >= EXIT_MAX) && !reset;
  assign accept         = host.cmd_valid && host.cmd_ready;
  assign cmd_long       = host.cmd_type >= DT_LONG_MIN;
  assign odd_reject     = accept && cmd_long && host.cmd_wc[0];
  assign err_odd_wc     = odd_reject;
  assign pkt_long       = dt >= DT_LONG_MIN;
  assign trail_done     = (state == ST_TRAIL) && (cnt == 16'd0);

  assign busy  = (state != ST_IDLE);
  assign hs_en = (state == ST_HS_ZERO) || (state == ST_SYNC) || (state == ST_HDR0) ||
                 (state == ST_HDR1) || (state == ST_PAYLOAD) || (state == ST_CRC) ||
                 (state == ST_TRAIL);
  assign lp_p  = (state == ST_IDLE);
  assign lp_n  = (state == ST_IDLE) || (state == ST_LP01);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 16'd0;
      exit_cnt <= EXIT_MAX;
      vc       <= 2'd0;
      dt       <= 6'd0;
      wc       <= 16'd0;
      last0_b7 <= 1'b0;
      last1_b7 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        vc <= host.cmd_vc;
        dt <= host.cmd_type;
        wc <= host.cmd_wc;
      end
      if (odd_reject || trail_done) begin
        exit_cnt <= 8'd0;
      end else if ((state == ST_IDLE) && (exit_cnt < EXIT_MAX)) begin
        exit_cnt <= exit_cnt + 8'd1;
      end
      // Trail inverts the MSB of the last HS byte, so freeze it while trailing.
      if (state != ST_TRAIL) begin
        last0_b7 <= lane0_byte[7];
        last1_b7 <= lane1_byte[7];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    lane0_byte      = 8'h00;
    lane1_byte      = 8'h00;
    host.data_ready = 1'b0;
    err_underrun    = 1'b0;
    crc_init        = 1'b0;
    crc_en          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !odd_reject) begin
          state_nxt = ST_LP01;
          cnt_nxt   = LPX_LOAD;
        end
      end
      ST_LP01: begin
        if (cnt == 16'd0) begin
          state_nxt = ST_LP00;
          cnt_nxt   = PREP_LOAD;
        end
      end
      ST_LP00: begin
        if (cnt == 16'd0) begin
          state_nxt = ST_HS_ZERO;
          cnt_nxt   = ZERO_LOAD;
        end
      end
      ST_HS_ZERO: begin
        if (cnt == 16'd0) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        lane0_byte = SYNC_BYTE;
        lane1_byte = SYNC_BYTE;
        crc_init   = 1'b1;
        state_nxt  = ST_HDR0;
      end
      ST_HDR0: begin
        lane0_byte = {vc, dt};
        lane1_byte = wc[7:0];
        state_nxt  = ST_HDR1;
      end
      ST_HDR1: begin
        lane0_byte = wc[15:8];
        lane1_byte = ecc6({wc, vc, dt});
        if (!pkt_long) begin
          state_nxt = ST_TRAIL;
          cnt_nxt   = TRAIL_LOAD;
        end else if (wc == 16'd0) begin
          state_nxt = ST_CRC;
        end else begin
          state_nxt = ST_PAYLOAD;
          cnt_nxt   = {1'b0, wc[15:1]} - 16'd1;
        end
      end
      ST_PAYLOAD: begin
        host.data_ready = 1'b1;
        crc_en          = 1'b1;
        if (host.data_valid) begin
          lane0_byte = host.data_i[7:0];
          lane1_byte = host.data_i[15:8];
        end else begin
          err_underrun = 1'b1;
        end
        if (cnt == 16'd0) state_nxt = ST_CRC;
      end
      ST_CRC: begin
        lane0_byte = crc[7:0];
        lane1_byte = crc[15:8];
        state_nxt  = ST_TRAIL;
        cnt_nxt    = TRAIL_LOAD;
      end
      ST_TRAIL: begin
        lane0_byte = {8{~last0_b7}};
        lane1_byte = {8{~last1_b7}};
        if (cnt == 16'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  csi2_crc16_2byte u_crc (
    .clk   (sys_clk),
    .rst   (reset),
    .init  (crc_init),
    .en    (crc_en),
    .byte0 (lane0_byte),
    .byte1 (lane1_byte),
    .crc   (crc)
  );

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Self-checking bench for csi2_packet_tx: table of packets with hand-computed headers/ECC/CRC,
// plus hand-written odd-word-count and mid-packet reset sequences.
module tb_csi2_packet_tx;
  import csi2_pkg::*;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] lane0_byte, lane1_byte;
  logic       hs_en, lp_p, lp_n, busy, err_underrun, err_odd_wc;
  int         checks = 0;
  int         errors = 0;

  csi2_packet_tx_if bus();

  csi2_packet_tx dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .host         (bus),
    .lane0_byte   (lane0_byte),
    .lane1_byte   (lane1_byte),
    .hs_en        (hs_en),
    .lp_p         (lp_p),
    .lp_n         (lp_n),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_odd_wc   (err_odd_wc)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          ur_at;      // first payload cycle with data_valid low
    int          ur_n;       // number of such cycles
    int          pay_kind;   // 0: generated pattern, 1: reference CRC vector
    logic [7:0]  h0l0, h0l1, h1l0, h1l1;
    bit          crc_fixed;  // use crc_exp instead of the bench CRC model
    logic [15:0] crc_exp;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] pay  [0:1023];
  logic [7:0] crcv [24];

  logic [7:0] r_l0 [0:1023];
  logic [7:0] r_l1 [0:1023];
  logic [1:0] r_lp [0:1023];
  logic       r_hs [0:1023];
  logic       r_dr [0:1023];
  logic       r_ur [0:1023];
  logic       r_busy [0:1023];
  logic       r_rdy [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] != b[k]) r = {1'b0, r[15:1]} ^ 16'h8408;
      else              r = {1'b0, r[15:1]};
    end
    return r;
  endfunction

  // Presents a command from the next cycle on, waits (bounded) for the handshake.
  // Returns at posedge+1 of the first cycle after the accepting cycle.
  task automatic issue(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                       output bit ok, output bit odd);
    int n;
    n = 0;
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_vc    = vc;
    bus.cmd_type  = dt;
    bus.cmd_wc    = wc;
    @(negedge sys_clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      n++;
    end
    ok  = (bus.cmd_ready === 1'b1);
    odd = (err_odd_wc === 1'b1);
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_packet(input int vi);
    vec_t        v;
    bit          ok, odd, is_long, ur;
    int          p, n, j, bad, urs, urmis, pc, exp_len;
    logic [15:0] c, exp_crc;
    logic [7:0]  e0, e1, prev0, prev1;
    v = vecs[vi];
    for (int k = 0; k < 1024; k++)
      pay[k] = (v.pay_kind == 1) ? ((k < 24) ? crcv[k] : 8'h00) : 8'((k * 37 + 5) & 255);
    is_long = (v.dt >= 6'h10);

    issue(v.vc, v.dt, v.wc, ok, odd);
    check($sformatf("v%0d accept", vi), 32'(ok), 32'd1);
    check($sformatf("v%0d odd flag", vi), 32'(odd), 32'd0);

    p = 0;
    n = 0;
    do begin
      if (bus.data_ready === 1'b1) begin
        if (p >= v.ur_at && p < v.ur_at + v.ur_n) begin
          bus.data_valid = 1'b0;
          bus.data_i     = 16'h0000;
        end else begin
          bus.data_valid = 1'b1;
          bus.data_i     = {pay[(2 * p + 1) % 1024], pay[(2 * p) % 1024]};
        end
        p++;
      end else begin
        bus.data_valid = 1'b0;
      end
      @(negedge sys_clk);
      r_l0[n]   = lane0_byte;
      r_l1[n]   = lane1_byte;
      r_lp[n]   = {lp_p, lp_n};
      r_hs[n]   = hs_en;
      r_dr[n]   = bus.data_ready;
      r_ur[n]   = err_underrun;
      r_busy[n] = busy;
      r_rdy[n]  = bus.cmd_ready;
      n++;
      @(posedge sys_clk); #1;
    end while (r_busy[n-1] === 1'b1 && n < 1024);
    bus.data_valid = 1'b0;

    exp_len = is_long ? (19 + int'(v.wc[15:1])) : 18;
    check($sformatf("v%0d length", vi), 32'(n), 32'(exp_len));

    bad = 0;
    for (int i = 0; i < 2; i++) if (r_lp[i] !== 2'b01 || r_hs[i] !== 1'b0) bad++;
    for (int i = 2; i < 4; i++) if (r_lp[i] !== 2'b00 || r_hs[i] !== 1'b0) bad++;
    check($sformatf("v%0d lp entry bad cycles", vi), 32'(bad), 32'd0);

    bad = 0;
    for (int i = 4; i < 10; i++)
      if (r_hs[i] !== 1'b1 || r_lp[i] !== 2'b00 || r_l0[i] !== 8'h00 || r_l1[i] !== 8'h00) bad++;
    check($sformatf("v%0d hs_zero bad cycles", vi), 32'(bad), 32'd0);

    check($sformatf("v%0d sync", vi), {15'd0, r_hs[10], r_l0[10], r_l1[10]}, {15'd0, 1'b1, 8'hB8, 8'hB8});
    check($sformatf("v%0d hdr0", vi), {16'd0, r_l0[11], r_l1[11]}, {16'd0, v.h0l0, v.h0l1});
    check($sformatf("v%0d hdr1", vi), {16'd0, r_l0[12], r_l1[12]}, {16'd0, v.h1l0, v.h1l1});
    prev0 = v.h1l0;
    prev1 = v.h1l1;
    j = 13;

    if (is_long) begin
      c = 16'hFFFF;
      bad = 0; urs = 0; urmis = 0; pc = 0;
      while (j < n && r_dr[j] === 1'b1 && pc < 512) begin
        ur = (pc >= v.ur_at && pc < v.ur_at + v.ur_n);
        e0 = ur ? 8'h00 : pay[2 * pc];
        e1 = ur ? 8'h00 : pay[2 * pc + 1];
        if (r_l0[j] !== e0 || r_l1[j] !== e1) bad++;
        if (r_ur[j] === 1'b1) urs++;
        if (r_ur[j] !== ur) urmis++;
        c = crc_byte(crc_byte(c, e0), e1);
        pc++;
        j++;
      end
      check($sformatf("v%0d payload cycles", vi), 32'(pc), {17'd0, v.wc[15:1]});
      check($sformatf("v%0d payload byte errors", vi), 32'(bad), 32'd0);
      check($sformatf("v%0d underrun pulses", vi), 32'(urs), 32'(v.ur_n));
      check($sformatf("v%0d underrun misplaced", vi), 32'(urmis), 32'd0);
      if (j > 1018) j = 1018;
      exp_crc = v.crc_fixed ? v.crc_exp : c;
      check($sformatf("v%0d crc", vi), {15'd0, r_hs[j], r_l1[j], r_l0[j]}, {15'd0, 1'b1, exp_crc});
      prev0 = exp_crc[7:0];
      prev1 = exp_crc[15:8];
      j++;
    end

    bad = 0;
    for (int i = 0; i < 4; i++)
      if (r_hs[j+i] !== 1'b1 || r_lp[j+i] !== 2'b00 ||
          r_l0[j+i] !== {8{~prev0[7]}} || r_l1[j+i] !== {8{~prev1[7]}}) bad++;
    check($sformatf("v%0d trail bad cycles", vi), 32'(bad), 32'd0);
    j += 4;
    check($sformatf("v%0d return to lp11", vi), {27'd0, r_hs[j], r_lp[j], r_busy[j], r_rdy[j]},
          {27'd0, 1'b0, 2'b11, 1'b0, 1'b0});
  endtask

  initial begin
    bit ok, odd;
    int bad, p, n;
    bus.cmd_valid  = 1'b0;
    bus.cmd_vc     = 2'd0;
    bus.cmd_type   = 6'd0;
    bus.cmd_wc     = 16'd0;
    bus.data_i     = 16'd0;
    bus.data_valid = 1'b0;

    crcv = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
             8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    vecs[0] = '{vc:2'd0, dt:DT_FS,    wc:16'h0001, ur_at:0, ur_n:0, pay_kind:0,
                h0l0:8'h00, h0l1:8'h01, h1l0:8'h00, h1l1:8'h1A, crc_fixed:1'b0, crc_exp:16'h0000};
    vecs[1] = '{vc:2'd1, dt:DT_FE,    wc:16'h0002, ur_at:0, ur_n:0, pay_kind:0,
                h0l0:8'h41, h0l1:8'h02, h1l0:8'h00, h1l1:8'h0D, crc_fixed:1'b0, crc_exp:16'h0000};
    vecs[2] = '{vc:2'd2, dt:6'h08,    wc:16'h8000, ur_at:0, ur_n:0, pay_kind:0,
                h0l0:8'h88, h0l1:8'h00, h1l0:8'h80, h1l1:8'h2C, crc_fixed:1'b0, crc_exp:16'h0000};
    vecs[3] = '{vc:2'd0, dt:DT_RAW8,  wc:16'h0280, ur_at:0, ur_n:0, pay_kind:0,
                h0l0:8'h2A, h0l1:8'h80, h1l0:8'h02, h1l1:8'h0E, crc_fixed:1'b0, crc_exp:16'h0000};
    vecs[4] = '{vc:2'd0, dt:DT_RAW8,  wc:16'h0018, ur_at:0, ur_n:0, pay_kind:1,
                h0l0:8'h2A, h0l1:8'h18, h1l0:8'h00, h1l1:8'h13, crc_fixed:1'b1, crc_exp:16'h00F0};
    vecs[5] = '{vc:2'd0, dt:DT_RAW10, wc:16'h0010, ur_at:2, ur_n:3, pay_kind:0,
                h0l0:8'h2B, h0l1:8'h10, h1l0:8'h00, h1l1:8'h31, crc_fixed:1'b0, crc_exp:16'h0000};
    vecs[6] = '{vc:2'd3, dt:DT_RAW8,  wc:16'h0000, ur_at:0, ur_n:0, pay_kind:0,
                h0l0:8'hEA, h0l1:8'h00, h1l0:8'h00, h1l1:8'h1F, crc_fixed:1'b1, crc_exp:16'hFFFF};

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("reset lines", {12'd0, lp_p, lp_n, hs_en, busy, lane0_byte, lane1_byte},
          {12'd0, 4'b1100, 16'h0000});
    check("reset status", {29'd0, bus.data_ready, err_underrun, err_odd_wc}, 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0;
    @(negedge sys_clk);
    check("ready after reset release", 32'(bus.cmd_ready), 32'd1);
    @(posedge sys_clk); #1;

    for (int i = 0; i < 7; i++) run_packet(i);

    // Odd word count on a long type: rejected, stays LP11, 4-cycle hold-off
    issue(2'd0, DT_RAW8, 16'h0003, ok, odd);
    check("odd accept", 32'(ok), 32'd1);
    check("odd err pulse", 32'(odd), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (bus.cmd_ready !== 1'b0 || lp_p !== 1'b1 || lp_n !== 1'b1 || hs_en !== 1'b0 ||
          busy !== 1'b0 || err_odd_wc !== 1'b0) bad++;
      @(posedge sys_clk); #1;
    end
    check("odd hold-off bad cycles", 32'(bad), 32'd0);
    @(negedge sys_clk);
    check("odd ready again", 32'(bus.cmd_ready), 32'd1);
    @(posedge sys_clk); #1;

    // Reset in the 10th payload cycle
    issue(2'd0, DT_RAW8, 16'h0280, ok, odd);
    p = 0;
    n = 0;
    while (n < 200) begin
      if (bus.data_ready === 1'b1) begin
        p++;
        bus.data_valid = 1'b1;
        bus.data_i     = 16'h1234;
      end
      if (p == 10) break;
      @(posedge sys_clk); #1;
      n++;
    end
    check("reached 10th payload cycle", 32'(p), 32'd10);
    reset = 1'b1;
    @(negedge sys_clk);
    check("cmd_ready in reset cycle", 32'(bus.cmd_ready), 32'd0);
    @(posedge sys_clk); #1;
    reset          = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge sys_clk);
    check("after reset lp/hs/busy", {28'd0, lp_p, lp_n, hs_en, busy}, {28'd0, 4'b1100});
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("cmd_ready after mid-packet reset", 32'(bus.cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2_packet_tx.md
Name: csi2_packet_tx

Overview:
- Two-lane MIPI CSI-2 packet transmitter, byte-level, one byte per lane per clock. It is the transmit counterpart of the existing two-lane CSI-2 receiver.
- Sequences the LP11 -> LP01 -> LP00 -> HS entry and emits HS-zero, sync (0xB8), packet header with ECC, payload, CRC16 and HS-trail, then returns to LP11.
- Drives an external per-lane 8:1 serializer (LSB first) and LP output buffers. Used for loopback test of the receiver and for forwarding processed frames.

Parameters:
- T_LPX, 2, cycles spent in LP01.
- T_PREPARE, 2, cycles spent in LP00 before HS.
- T_ZERO, 6, cycles of HS 0x00 before sync.
- T_TRAIL, 4, cycles of HS-trail.
- T_EXIT, 4, minimum cycles in LP11 before the next command is accepted.

Ports:
- sys_clk  in  1  byte clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  packet request.
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready.
- cmd_vc  in  2  virtual channel.
- cmd_type  in  6  data type. Values < 0x10 are short packets; values >= 0x10 are long packets.
- cmd_wc  in  16  word count (long packet) or data field (short packet).
- data_i  in  16  payload; [7:0] goes to lane0, [15:8] goes to lane1.
- data_valid  in  1  payload word available.
- data_ready  out  1  payload word consumed when data_valid && data_ready.
- lane0_byte  out  8  HS byte for lane0.
- lane1_byte  out  8  HS byte for lane1.
- hs_en  out  1  serializer / HS driver enable.
- lp_p  out  1  LP P level, both lanes.
- lp_n  out  1  LP N level, both lanes.
- busy  out  1  high in any state other than IDLE.
- err_underrun  out  1  one-cycle pulse per payload cycle with no valid data.
- err_odd_wc  out  1  one-cycle pulse when a long-packet command is rejected.

Behaviour:
- Reset values: state IDLE, exit counter = T_EXIT (so a command can be accepted immediately), all bytes 0x00, hs_en=0, lp_p=1, lp_n=1, errors 0, data_ready=0, cmd_ready=0 in the reset cycle.
- Reset mid-packet: next cycle returns to IDLE/LP11 at once, with no trail.
- IDLE:
  - lp=11; cmd_ready=1 once the exit counter >= T_EXIT.
  - On accept: latch vc/type/wc.
  - If the packet is long and wc[0]=1: pulse err_odd_wc, stay IDLE, clear the exit counter.
  - Otherwise go to LP01.
- LP01: lp=01 for T_LPX cycles, then LP00.
- LP00: lp=00 for T_PREPARE cycles, then HS_ZERO.
- hs_en and lp: hs_en=1 from HS_ZERO through TRAIL inclusive. lp=00 whenever hs_en=1.
- HS_ZERO: both lanes 0x00 for T_ZERO cycles.
- SYNC: 1 cycle, both lanes 0xB8.
- HDR0: 1 cycle, lane0 = {vc,type}, lane1 = wc[7:0].
- HDR1: 1 cycle, lane0 = wc[15:8], lane1 = ECC.
  - ECC = 6-bit CSI-2 Hamming code over header bits [23:0]; ECC bits [7:6] = 0.
  - Next state: TRAIL for a short packet, CRC if long with wc=0, otherwise PAYLOAD.
- PAYLOAD: wc/2 cycles.
  - data_ready=1 (combinational on state).
  - With data_valid: lanes = data_i.
  - Without data_valid: lanes = 0x00 and err_underrun pulses. The cycle still counts and the 0x00 bytes enter the CRC. The transmitter never pauses HS.
- CRC: 1 cycle, lane0 = crc[7:0], lane1 = crc[15:8].
  - CRC16 uses reflected polynomial 0x8408 (x^16+x^12+x^5+1), seed 0xFFFF, no final XOR.
  - Updated with 2 bytes per cycle: lane0 byte first, LSB first.
  - Reseeded in SYNC.
- TRAIL: T_TRAIL cycles. Each lane drives {8{~b}}, where b = bit 7 of that lane's last transmitted byte.
- Return to LP: then hs_en=0, lp=11, state IDLE, exit counter cleared.
- Counters: one 16-bit down-counter shared for timing and payload, loaded on state entry. wc/2 is computed as wc[15:1].
- Latency: an accepted command produces the sync byte exactly T_LPX + T_PREPARE + T_ZERO + 1 cycles later.

Decomposition:
- Package csi2_pkg holds:
  - state enum;
  - SYNC_BYTE = 0xB8;
  - CRC_SEED = 0xFFFF;
  - short/long DT threshold 0x10;
  - data types FS=0x00, FE=0x01, RAW10=0x2B, RAW8=0x2A;
  - function ecc6(hdr[23:0]).
- Sub-module csi2_crc16_2byte: init, en, two bytes in, crc out, registered update. This sub-module is shared with the receiver-side CRC check.

Test Plan:
- Short FS: vc=0, type=0x00, wc=0x0001.
  - Bytes after 6 zero cycles: B8/B8, 00/01, 00/1A.
  - Then 4 cycles of FF/FF (bit 7 of the last bytes was 0), hs_en falls, lp returns to 11.
- Long RAW8: type 0x2A, wc=0x0280.
  - Header lane0 2A,02; lane1 80,0E.
  - Exactly 320 payload cycles with data_ready high, then one CRC cycle.
- CRC vector: long packet wc=24, payload bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> CRC cycle lane0=F0, lane1=00.
- Underrun: drop data_valid for 3 payload cycles.
  - 3 err_underrun pulses and 00/00 on the lanes in those cycles.
  - Total payload cycle count unchanged; CRC matches the software model including the zero bytes.
- Odd wc 0x0003 with long type:
  - err_odd_wc pulses, lines stay LP11, hs_en stays 0.
  - Next command is accepted only after 4 cycles.
- Reset asserted in the 10th payload cycle -> next cycle lp=11, hs_en=0, busy=0, and cmd_ready=1 the cycle after.
